// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit between the core and a req/gnt/rvalid data memory port.
// Forms aligned address, byte enables and replicated store data, returns
// sign/zero-extended load data, and flags misaligned/illegal accesses and timeouts.
module lsu_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_funct3_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_rvalid_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_err_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int               CNT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  localparam int               TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TO_LAST_INT);
  localparam logic             TO_EN       = (TIMEOUT_CYCLES != 0);

  logic [1:0]      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_funct3;
  logic [1:0]      r_byteOff;
  logic            r_req;
  logic            r_we;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_rvalid;
  logic            r_err;
  logic [XLEN-1:0] r_rdata;

  logic            w_accept;
  logic            w_illegal;
  logic            w_misaligned;
  logic            w_fault;
  logic            w_timeout;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_loadData;

  assign lsu_ready_o  = (r_state == S_IDLE);
  assign w_accept     = lsu_valid_i && lsu_ready_o;
  assign w_timeout    = TO_EN && (r_state != S_IDLE) && (r_cnt == TO_LAST);

  assign mem_req_o    = r_req;
  assign mem_we_o     = r_we;
  assign mem_be_o     = r_be;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign lsu_rvalid_o = r_rvalid;
  assign lsu_err_o    = r_err;
  assign lsu_rdata_o  = r_rdata;

  // Decode the incoming request: legality, alignment, byte enables and write lane replication
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = lsu_wdata_i;
    if (lsu_we_i) begin
      w_illegal = (lsu_funct3_i >= 3'd3);
    end else begin
      w_illegal = (lsu_funct3_i == 3'd3) || (lsu_funct3_i == 3'd6) || (lsu_funct3_i == 3'd7);
    end
    case (lsu_funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << lsu_addr_i[1:0];
        w_wdata = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        w_misaligned = lsu_addr_i[0];
        w_be         = 4'b0011 << lsu_addr_i[1:0];
        w_wdata      = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        w_misaligned = (lsu_addr_i[1:0] != 2'b00);
        w_be         = 4'b1111;
        w_wdata      = lsu_wdata_i;
      end
    endcase
    w_fault = w_illegal || w_misaligned;
  end

  // Extract and extend the addressed byte/half from the returned memory word
  always_comb begin
    w_shifted  = mem_rdata_i >> {r_byteOff, 3'b000};
    w_loadData = mem_rdata_i;
    case (r_funct3)
      3'd0:    w_loadData = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      3'd4:    w_loadData = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      3'd1:    w_loadData = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      3'd5:    w_loadData = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: w_loadData = mem_rdata_i;
    endcase
  end

  // Control FSM, memory request registers and timeout counter
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_funct3  <= 3'd0;
      r_byteOff <= 2'd0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= 4'b0000;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (!w_fault) begin
              r_state   <= S_REQ;
              r_req     <= 1'b1;
              r_we      <= lsu_we_i;
              r_funct3  <= lsu_funct3_i;
              r_byteOff <= lsu_addr_i[1:0];
              r_be      <= w_be;
              r_addr    <= {lsu_addr_i[XLEN-1:2], 2'b00};
              r_wdata   <= w_wdata;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_timeout) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end else if (mem_gnt_i) begin
            r_state <= S_WAIT;
            r_req   <= 1'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (mem_rvalid_i || w_timeout) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Registered one-cycle response; data holds until the next response
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      if ((r_state == S_IDLE) && w_accept && w_fault) begin
        r_rvalid <= 1'b1;
        r_err    <= 1'b1;
        r_rdata  <= '0;
      end else if ((r_state == S_WAIT) && mem_rvalid_i) begin
        r_rvalid <= 1'b1;
        r_err    <= 1'b0;
        r_rdata  <= r_we ? '0 : w_loadData;
      end else if (w_timeout) begin
        r_rvalid <= 1'b1;
        r_err    <= 1'b1;
        r_rdata  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed vectors for lsu_unit with a response scoreboard and monitor.
module tb_lsu_unit;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic        lsu_we_i;
  logic [2:0]  lsu_funct3_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  resp_t expQ[$];
  resp_t monExp;
  int    total = 0;
  int    bad   = 0;

  lsu_unit #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_we_i(lsu_we_i),
    .lsu_funct3_i(lsu_funct3_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Monitor: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (lsu_rvalid_o) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpectedResp: got rvalid err=%0b rdata=%h, required no response", lsu_err_o, lsu_rdata_o);
      end else begin
        monExp = expQ.pop_front();
        if (lsu_err_o !== monExp.err || lsu_rdata_o !== monExp.data) begin
          bad++;
          $display("[TB] FAIL response: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   lsu_err_o, lsu_rdata_o, monExp.err, monExp.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Issue one request at the current negedge and play the memory side;
  // returns on the negedge where the response pulse is visible
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int gntDelay, input int rvDelay, input logic expFault,
                               input logic [3:0] expBe, input logic [31:0] expWdata,
                               input logic [31:0] expData);
    logic [31:0] expAddr;
    expAddr = addr & 32'hFFFF_FFFC;
    checkOutput("readyBeforeIssue", 32'(lsu_ready_o), 32'd1);
    lsu_valid_i  = 1'b1;
    lsu_we_i     = we;
    lsu_funct3_i = f3;
    lsu_addr_i   = addr;
    lsu_wdata_i  = wdata;
    if (expFault) expQ.push_back('{1'b1, 32'h0});
    else          expQ.push_back('{1'b0, expData});
    @(negedge clk);
    lsu_valid_i = 1'b0;
    if (expFault) begin
      checkOutput("faultNoReq", 32'(mem_req_o), 32'd0);
      checkOutput("faultRespNextCycle", 32'(lsu_rvalid_o), 32'd1);
      checkOutput("faultReady", 32'(lsu_ready_o), 32'd1);
    end else begin
      checkOutput("reqAsserted", 32'(mem_req_o), 32'd1);
      checkOutput("memAddr", mem_addr_o, expAddr);
      checkOutput("memBe", 32'(mem_be_o), 32'(expBe));
      checkOutput("memWdata", mem_wdata_o, expWdata);
      checkOutput("memWe", 32'(mem_we_o), 32'(we));
      for (int i = 0; i < gntDelay; i++) begin
        @(negedge clk);
        checkOutput("holdReq", 32'(mem_req_o), 32'd1);
        checkOutput("holdAddr", mem_addr_o, expAddr);
        checkOutput("holdBe", 32'(mem_be_o), 32'(expBe));
        checkOutput("holdWdata", mem_wdata_o, expWdata);
      end
      mem_gnt_i = 1'b1;
      @(negedge clk);
      mem_gnt_i = 1'b0;
      checkOutput("reqDropAfterGnt", 32'(mem_req_o), 32'd0);
      for (int i = 1; i < rvDelay; i++) @(negedge clk);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rdata;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      checkOutput("rvalidLatency", 32'(lsu_rvalid_o), 32'd1);
      checkOutput("readyInRespCycle", 32'(lsu_ready_o), 32'd1);
    end
  endtask

  // Load that never completes; error pulse must appear 8 cycles after accept
  task automatic checkTimeout(input logic [31:0] addr, input logic giveGnt);
    int hitAt;
    hitAt        = 0;
    lsu_valid_i  = 1'b1;
    lsu_we_i     = 1'b0;
    lsu_funct3_i = 3'd2;
    lsu_addr_i   = addr;
    expQ.push_back('{1'b1, 32'h0});
    @(negedge clk);
    lsu_valid_i = 1'b0;
    mem_gnt_i   = giveGnt;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    for (int k = 2; k <= 20; k++) begin
      if (hitAt == 0 && lsu_rvalid_o) hitAt = k;
      if (hitAt == 0) @(negedge clk);
    end
    checkOutput("timeoutCycle", 32'(hitAt), 32'd9);
    checkOutput("timeoutReqLow", 32'(mem_req_o), 32'd0);
    checkOutput("timeoutReady", 32'(lsu_ready_o), 32'd1);
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_gnt_i    = 1'b1;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b0;
    checkOutput("lateRespDropped", 32'(lsu_rvalid_o), 32'd0);
  endtask

  // Main directed sequence
  initial begin
    rstn_i       = 1'b0;
    lsu_valid_i  = 1'b0;
    lsu_we_i     = 1'b0;
    lsu_funct3_i = 3'd0;
    lsu_addr_i   = 32'h0;
    lsu_wdata_i  = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    @(negedge clk);
    checkOutput("resetReady", 32'(lsu_ready_o), 32'd1);
    checkOutput("resetReq", 32'(mem_req_o), 32'd0);
    checkOutput("resetRvalid", 32'(lsu_rvalid_o), 32'd0);
    checkOutput("resetErr", 32'(lsu_err_o), 32'd0);
    checkOutput("resetRdata", lsu_rdata_o, 32'h0);
    checkOutput("resetBe", 32'(mem_be_o), 32'h0);
    checkOutput("resetAddr", mem_addr_o, 32'h0);
    rstn_i = 1'b1;
    @(negedge clk);

    // Stores and loads through the memory port
    applyStimulus(1'b1, 3'd0, 32'h103, 32'h0000_00AB, 32'hDEAD_BEEF, 0, 1, 1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0);
    applyStimulus(1'b0, 3'd0, 32'h101, 32'h0, 32'h1234_80FF, 1, 1, 1'b0, 4'b0010, 32'h0, 32'hFFFF_FF80);
    applyStimulus(1'b0, 3'd4, 32'h101, 32'h0, 32'h1234_80FF, 0, 2, 1'b0, 4'b0010, 32'h0, 32'h0000_0080);
    applyStimulus(1'b0, 3'd1, 32'h102, 32'h0, 32'h1234_80FF, 2, 1, 1'b0, 4'b1100, 32'h0, 32'h0000_1234);
    applyStimulus(1'b0, 3'd1, 32'h100, 32'h0, 32'h0000_8001, 0, 1, 1'b0, 4'b0011, 32'h0, 32'hFFFF_8001);
    applyStimulus(1'b0, 3'd5, 32'h100, 32'h0, 32'h0000_8001, 0, 1, 1'b0, 4'b0011, 32'h0, 32'h0000_8001);
    applyStimulus(1'b0, 3'd0, 32'h103, 32'h0, 32'h7F00_0000, 0, 1, 1'b0, 4'b1000, 32'h0, 32'h0000_007F);
    applyStimulus(1'b1, 3'd1, 32'h102, 32'h1234_ABCD, 32'h0, 1, 1, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
    applyStimulus(1'b1, 3'd2, 32'h010, 32'hCAFE_F00D, 32'h5555_5555, 0, 3, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0);
    applyStimulus(1'b0, 3'd2, 32'h200, 32'h0, 32'h89AB_CDEF, 3, 2, 1'b0, 4'b1111, 32'h0, 32'h89AB_CDEF);

    // Misaligned and illegal requests, issued back-to-back
    applyStimulus(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 1, 1'b1, 4'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 0, 1, 1'b1, 4'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1, 1'b1, 4'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 3'd7, 32'h100, 32'h0, 32'h0, 0, 1, 1'b1, 4'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1, 1'b1, 4'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0, 1, 1'b1, 4'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1, 1'b1, 4'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 3'd2, 32'h104, 32'h0, 32'h0BAD_F00D, 0, 1, 1'b0, 4'b1111, 32'h0, 32'h0BAD_F00D);

    // Timeouts with the request stuck in WAIT and in REQ
    checkTimeout(32'h300, 1'b1);
    checkTimeout(32'h304, 1'b0);

    // Reset while waiting for data: no response afterwards
    lsu_valid_i  = 1'b1;
    lsu_we_i     = 1'b0;
    lsu_funct3_i = 3'd2;
    lsu_addr_i   = 32'h400;
    @(negedge clk);
    lsu_valid_i = 1'b0;
    mem_gnt_i   = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    checkOutput("waitNotReady", 32'(lsu_ready_o), 32'd0);
    #2 rstn_i = 1'b0;
    #1;
    checkOutput("resetWaitReq", 32'(mem_req_o), 32'd0);
    checkOutput("resetWaitReady", 32'(lsu_ready_o), 32'd1);
    @(negedge clk);
    rstn_i = 1'b1;

    // Reset while the request is on the bus
    lsu_valid_i  = 1'b1;
    lsu_we_i     = 1'b1;
    lsu_funct3_i = 3'd2;
    lsu_addr_i   = 32'h404;
    lsu_wdata_i  = 32'h1111_2222;
    @(negedge clk);
    lsu_valid_i = 1'b0;
    checkOutput("reqBeforeReset", 32'(mem_req_o), 32'd1);
    #2 rstn_i = 1'b0;
    #1;
    checkOutput("resetDropsReq", 32'(mem_req_o), 32'd0);
    checkOutput("resetReqReady", 32'(lsu_ready_o), 32'd1);
    @(negedge clk);
    rstn_i       = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_gnt_i    = 1'b1;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("noRespAfterReset", 32'(lsu_rvalid_o), 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
